// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester port bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          req;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, adr, wd,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, adr, wd,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of the unified instruction/data memory
module mem_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int MAX_HOLD   = 8,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int            HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    // One-hot owner encoding so each grant is a raw state flop bit.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [HW-1:0] hold_cnt;
    logic          last_served;

    logic          req0;
    logic          req1;
    logic          beat0;
    logic          beat1;
    logic          other_req;
    logic          hold_at_limit;

    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    assign req0 = p0.req;
    assign req1 = p1.req;

    assign p0.gnt = state_q[0];
    assign p1.gnt = state_q[1];

    // A beat is whatever the current owner presents while its request is up.
    assign beat0 = state_q[0] & req0;
    assign beat1 = state_q[1] & req1;

    // The non-owner is waiting; this is what makes the hold counter run.
    assign other_req     = (state_q[0] & req1) | (state_q[1] & req0);
    assign hold_at_limit = (hold_cnt == HOLD_LAST);

    assign p0.rvalid = rvalid0_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rvalid = rvalid1_q;
    assign p1.rdata  = rdata1_q;

    // Ownership decision: idle tie-break, release/handover and hold-time preemption.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (FIXED_PRIO || last_served) ? OWN0 : OWN1;
                end else if (req0) begin
                    state_d = OWN0;
                end else if (req1) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_d = req1 ? OWN1 : IDLE;
                end else if (req1 && !FIXED_PRIO && hold_at_limit) begin
                    state_d = OWN1;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_d = req0 ? OWN0 : IDLE;
                end else if (req0 && (FIXED_PRIO || hold_at_limit)) begin
                    // Under fixed priority port 1's beat this cycle still lands.
                    state_d = OWN0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Owner state, hold counter and the round-robin history bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hold_cnt    <= '0;
            last_served <= 1'b1;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                hold_cnt <= '0;
            end else if (!other_req) begin
                hold_cnt <= '0;
            end else if (!hold_at_limit) begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (state_q == OWN0 && state_d != OWN0) begin
                last_served <= 1'b0;
            end else if (state_q == OWN1 && state_d != OWN1) begin
                last_served <= 1'b1;
            end
        end
    end

    // Memory-side mux; write enable is also gated by reset so a write racing reset is dropped.
    always_comb begin
        mem_we  = 1'b0;
        mem_adr = '0;
        mem_wd  = '0;
        if (beat0) begin
            mem_we  = reset & p0.we;
            mem_adr = p0.adr;
            mem_wd  = p0.wd;
        end else if (beat1) begin
            mem_we  = reset & p1.we;
            mem_adr = p1.adr;
            mem_wd  = p1.wd;
        end
    end

    // Registered read return: capture memory data and pulse rvalid once per read beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= beat0 & ~p0.we;
            rvalid1_q <= beat1 & ~p1.we;
            if (beat0 && !p0.we) begin
                rdata0_q <= mem_rd;
            end
            if (beat1 && !p1.we) begin
                rdata1_q <= mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.DW(32), .AW(32)) rr0 ();
    mem_arbiter_if #(.DW(32), .AW(32)) rr1 ();
    mem_arbiter_if #(.DW(32), .AW(32)) fp0 ();
    mem_arbiter_if #(.DW(32), .AW(32)) fp1 ();

    logic        rr_mem_we;
    logic [31:0] rr_mem_adr;
    logic [31:0] rr_mem_wd;
    logic [31:0] rr_mem_rd;
    logic        fp_mem_we;
    logic [31:0] fp_mem_adr;
    logic [31:0] fp_mem_wd;
    logic [31:0] fp_mem_rd;

    mem_arbiter #(.DW(32), .AW(32), .MAX_HOLD(8), .FIXED_PRIO(1'b0)) dut_rr (
        .clk     (clk),
        .reset   (reset),
        .p0      (rr0),
        .p1      (rr1),
        .mem_we  (rr_mem_we),
        .mem_adr (rr_mem_adr),
        .mem_wd  (rr_mem_wd),
        .mem_rd  (rr_mem_rd)
    );

    mem_arbiter #(.DW(32), .AW(32), .MAX_HOLD(8), .FIXED_PRIO(1'b1)) dut_fp (
        .clk     (clk),
        .reset   (reset),
        .p0      (fp0),
        .p1      (fp1),
        .mem_we  (fp_mem_we),
        .mem_adr (fp_mem_adr),
        .mem_wd  (fp_mem_wd),
        .mem_rd  (fp_mem_rd)
    );

    // Unified memory behind the round-robin instance.
    logic [31:0] mem [0:15];
    logic        mem_preload;
    assign rr_mem_rd = mem[rr_mem_adr[5:2]];
    assign fp_mem_rd = 32'h0;

    always @(posedge clk) begin
        if (mem_preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'h2002_0005 : 32'h0;
        end else if (rr_mem_we) begin
            mem[rr_mem_adr[5:2]] <= rr_mem_wd;
        end
    end

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] wd;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rd0_q[$];
    logic [31:0] rd1_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w.adr = a;
        w.wd  = d;
        wr_q.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT response is popped against the scoreboard.
    always @(negedge clk) begin : monitor
        wr_t w;
        if (rr0.rvalid === 1'b1) begin
            if (rd0_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rvalid0_unexpected: got rdata 0x%08h, required no response", rr0.rdata);
            end else begin
                check32("rdata0", rr0.rdata, rd0_q.pop_front());
            end
        end
        if (rr1.rvalid === 1'b1) begin
            if (rd1_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rvalid1_unexpected: got rdata 0x%08h, required no response", rr1.rdata);
            end else begin
                check32("rdata1", rr1.rdata, rd1_q.pop_front());
            end
        end
        if (rr_mem_we !== 1'b0) begin
            if (wr_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL mem_we_unexpected: got we=%b adr 0x%08h, required no write", rr_mem_we, rr_mem_adr);
            end else begin
                w = wr_q.pop_front();
                check32("mem_adr", rr_mem_adr, w.adr);
                check32("mem_wd", rr_mem_wd, w.wd);
            end
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        mem_preload = 1'b1;
        rr0.req = 0; rr0.we = 0; rr0.adr = 0; rr0.wd = 0;
        rr1.req = 0; rr1.we = 0; rr1.adr = 0; rr1.wd = 0;
        fp0.req = 0; fp0.we = 0; fp0.adr = 0; fp0.wd = 0;
        fp1.req = 0; fp1.we = 0; fp1.adr = 0; fp1.wd = 0;
        tick();
        tick();
        mem_preload = 1'b0;

        // Reset state
        check1("rst_gnt0", rr0.gnt, 1'b0);
        check1("rst_gnt1", rr1.gnt, 1'b0);
        check1("rst_rvalid0", rr0.rvalid, 1'b0);
        check1("rst_rvalid1", rr1.rvalid, 1'b0);
        check32("rst_rdata0", rr0.rdata, 32'h0);
        check32("rst_rdata1", rr1.rdata, 32'h0);
        check1("rst_mem_we", rr_mem_we, 1'b0);
        check1("rst_fp_gnt1", fp1.gnt, 1'b0);
        reset = 1'b1;

        // Single read by port 0
        rr0.req = 1; rr0.we = 0; rr0.adr = 32'h0;
        check1("t1_gnt0_not_yet", rr0.gnt, 1'b0);
        tick();
        check1("t1_gnt0", rr0.gnt, 1'b1);
        check1("t1_gnt1", rr1.gnt, 1'b0);
        rd0_q.push_back(32'h2002_0005);
        tick();
        check1("t1_rvalid0", rr0.rvalid, 1'b1);
        rr0.req = 0;
        tick();
        check1("t1_rvalid0_pulse", rr0.rvalid, 1'b0);
        check1("t1_idle_gnt0", rr0.gnt, 1'b0);
        check32("t1_idle_adr", rr_mem_adr, 32'h0);
        check32("t1_idle_wd", rr_mem_wd, 32'h0);

        // Port 1 write burst
        rr1.req = 1; rr1.we = 1; rr1.adr = 32'h0; rr1.wd = 32'h1;
        for (int k = 0; k < 4; k++) push_wr(32'(k * 4), 32'(k + 1));
        tick();
        check1("t2_gnt1", rr1.gnt, 1'b1);
        for (int k = 1; k < 4; k++) begin
            tick();
            rr1.adr = 32'(k * 4);
            rr1.wd  = 32'(k + 1);
        end
        tick();
        rr1.req = 0; rr1.we = 0;
        tick();
        check1("t2_idle_gnt1", rr1.gnt, 1'b0);

        // Both requesting: alternate every 8 cycles, port 0 first
        rr0.req = 1; rr0.we = 1; rr0.adr = 32'h10; rr0.wd = 32'hA0;
        rr1.req = 1; rr1.we = 1; rr1.adr = 32'h14; rr1.wd = 32'hB0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (((i / 8) % 2) == 0) begin
                check1("t3_rr_gnt0", rr0.gnt, 1'b1);
                check1("t3_rr_gnt1", rr1.gnt, 1'b0);
                push_wr(32'h10, 32'hA0);
            end else begin
                check1("t3_rr_gnt0", rr0.gnt, 1'b0);
                check1("t3_rr_gnt1", rr1.gnt, 1'b1);
                push_wr(32'h14, 32'hB0);
            end
        end
        tick();
        rr0.req = 0; rr0.we = 0; rr1.req = 0; rr1.we = 0;
        tick();
        check1("t3_idle_gnt0", rr0.gnt, 1'b0);
        check1("t3_idle_gnt1", rr1.gnt, 1'b0);

        // Read in last owned cycle before preemption, then release handover
        rr0.req = 1; rr0.we = 0; rr0.adr = 32'h10;
        rr1.req = 1; rr1.we = 1; rr1.adr = 32'h18; rr1.wd = 32'hC0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check1("t4_gnt0", rr0.gnt, 1'b1);
            rd0_q.push_back(32'hA0);
        end
        tick();
        check1("t4_handover_gnt1", rr1.gnt, 1'b1);
        check1("t4_handover_rvalid0", rr0.rvalid, 1'b1);
        push_wr(32'h18, 32'hC0);
        rr0.req = 0;
        tick();
        push_wr(32'h18, 32'hC0);
        tick();
        rr1.req = 0; rr1.we = 0;
        rr0.req = 1; rr0.we = 0; rr0.adr = 32'h18;
        tick();
        check1("t4_drop_gnt0", rr0.gnt, 1'b1);
        check1("t4_drop_gnt1", rr1.gnt, 1'b0);
        rd0_q.push_back(32'hC0);
        tick();
        rr0.req = 0;
        tick();
        check1("t4_idle_gnt0", rr0.gnt, 1'b0);

        // Reset asserted mid-burst
        rr1.req = 1; rr1.we = 1; rr1.adr = 32'h1C; rr1.wd = 32'hD0;
        tick();
        check1("t5_gnt1", rr1.gnt, 1'b1);
        push_wr(32'h1C, 32'hD0);
        tick();
        rr1.wd = 32'hD1;
        #2;
        reset = 1'b0;
        #1;
        check1("t5_async_gnt1", rr1.gnt, 1'b0);
        check1("t5_async_mem_we", rr_mem_we, 1'b0);
        check1("t5_async_rvalid0", rr0.rvalid, 1'b0);
        check1("t5_async_rvalid1", rr1.rvalid, 1'b0);
        check32("t5_async_rdata0", rr0.rdata, 32'h0);
        tick();
        check32("t5_no_write", mem[7], 32'hD0);
        reset = 1'b1;
        rr0.req = 1; rr0.we = 0; rr0.adr = 32'h0;
        rr1.req = 1; rr1.we = 0; rr1.adr = 32'h4;
        tick();
        check1("t5_tie_gnt0", rr0.gnt, 1'b1);
        check1("t5_tie_gnt1", rr1.gnt, 1'b0);
        rd0_q.push_back(32'h1);
        tick();
        rr0.req = 0;
        tick();
        check1("t5_p1_gnt1", rr1.gnt, 1'b1);
        rd1_q.push_back(32'h2);
        tick();
        rr1.req = 0;
        tick();

        // Fixed priority: port 0 preempts port 1 and is never preempted
        fp1.req = 1; fp1.we = 1; fp1.adr = 32'h20; fp1.wd = 32'h55;
        tick();
        check1("fp_gnt1", fp1.gnt, 1'b1);
        tick();
        tick();
        tick();
        fp0.req = 1; fp0.we = 1; fp0.adr = 32'h24; fp0.wd = 32'h66;
        check1("fp_p1_beat_we", fp_mem_we, 1'b1);
        check32("fp_p1_beat_adr", fp_mem_adr, 32'h20);
        check1("fp_p1_still_gnt", fp1.gnt, 1'b1);
        tick();
        check1("fp_preempt_gnt0", fp0.gnt, 1'b1);
        check1("fp_preempt_gnt1", fp1.gnt, 1'b0);
        check32("fp_p0_beat_adr", fp_mem_adr, 32'h24);
        for (int i = 0; i < 20; i++) begin
            tick();
            check1("fp_hold_gnt0", fp0.gnt, 1'b1);
            check1("fp_hold_gnt1", fp1.gnt, 1'b0);
        end
        fp0.req = 0; fp0.we = 0;
        tick();
        check1("fp_release_gnt1", fp1.gnt, 1'b1);
        check1("fp_release_gnt0", fp0.gnt, 1'b0);
        fp1.req = 0; fp1.we = 0;
        tick();
        check1("fp_idle_gnt1", fp1.gnt, 1'b0);

        tick();
        tick();
        check32("wr_q_drained", 32'(wr_q.size()), 32'h0);
        check32("rd0_q_drained", 32'(rd0_q.size()), 32'h0);
        check32("rd1_q_drained", 32'(rd1_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
